// File: rtl/mod6_pkg.sv
// Shared constants, FSM encoding and modular-distance helper for the mod-6 move arbiter.
package mod6_pkg;

  localparam int MOD = 6;
  localparam int W   = 3;

  localparam logic [W-1:0] MOD_W  = W'(MOD);
  localparam logic [W-1:0] MOD_M1 = W'(MOD - 1);
  localparam logic [W-1:0] HALF_W = W'(MOD / 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_t;

  // (t - q) mod MOD for legal t, q; one conditional subtract suffices since the sum is below 2*MOD.
  function automatic logic [W-1:0] mod_dist(input logic [W-1:0] t, input logic [W-1:0] q);
    logic [W:0] s;
    s = {1'b0, t} + {1'b0, MOD_W} - {1'b0, q};
    if (s >= {1'b0, MOD_W}) s = s - {1'b0, MOD_W};
    return s[W-1:0];
  endfunction

endpackage

// File: rtl/mod6_step_counter.sv
// Enabled up/down mod-MOD counter; moves one position per enabled cycle, wrapping at both ends.
// Registered output, q=0 on synchronous reset; no backpressure.
module mod6_step_counter
  import mod6_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         dir,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (en) begin
      if (dir) r_q <= (r_q == MOD_M1) ? '0 : r_q + 1'b1;
      else     r_q <= (r_q == '0) ? MOD_M1 : r_q - 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/mod6_move_arb.sv
// Two-requester round-robin owner of a shared mod-6 counter, stepping it along the shortest path to a target.
// Ack arrives 2..5 cycles after the request is seen; requests hold until ack, one service in flight at a time.
module mod6_move_arb
  import mod6_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req,
  input  logic [W-1:0] tgt0,
  input  logic [W-1:0] tgt1,
  output logic [1:0]   ack,
  output logic         err,
  output logic         busy,
  output logic         owner,
  output logic         dir,
  output logic [W-1:0] q
);

  state_t       r_state, w_state_nxt;
  logic         r_owner, r_last, r_dir, r_err;
  logic [W-1:0] r_rem;
  logic         w_grant_vld, w_grant_idx;
  logic [W-1:0] w_tgt, w_d, w_rem_ld, w_q;
  logic         w_illegal, w_zero, w_up, w_cnt_en;

  assign w_grant_vld = |req;

  // On a tie the requester that was not served last wins.
  always_comb begin
    w_grant_idx = 1'b0;
    case (req)
      2'b10:   w_grant_idx = 1'b1;
      2'b11:   w_grant_idx = ~r_last;
      default: w_grant_idx = 1'b0;
    endcase
  end

  assign w_tgt     = r_owner ? tgt1 : tgt0;
  assign w_illegal = (w_tgt >= MOD_W);
  assign w_d       = mod_dist(w_tgt, w_q);
  assign w_zero    = (w_d == '0);
  assign w_up      = (w_d <= HALF_W);
  assign w_rem_ld  = w_up ? w_d : (MOD_W - w_d);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant_vld) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = (w_illegal || w_zero) ? DONE : STEP;
      STEP:    if (r_rem == W'(1)) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack      = 2'b00;
    busy     = 1'b0;
    w_cnt_en = 1'b0;
    case (r_state)
      LOAD:    busy = 1'b1;
      STEP:    begin busy = 1'b1; w_cnt_en = 1'b1; end
      DONE:    begin busy = 1'b1; ack = r_owner ? 2'b10 : 2'b01; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_dir   <= 1'b1;
      r_err   <= 1'b0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_grant_vld) r_owner <= w_grant_idx;
        LOAD: begin
          r_err <= w_illegal;
          if (!w_illegal && !w_zero) begin
            r_dir <= w_up;
            r_rem <= w_rem_ld;
          end
        end
        STEP: r_rem <= r_rem - 1'b1;
        DONE: begin
          r_last <= r_owner;
          r_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  mod6_step_counter u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (w_cnt_en),
    .dir   (r_dir),
    .q     (w_q)
  );

  assign q     = w_q;
  assign err   = r_err;
  assign owner = r_owner;
  assign dir   = r_dir;

endmodule
